dec_counter_reload: RTL and testbench

- Programmable decrementing counter with parallel load and auto-reload. It is the count-down counterpart of the team's incrementing load counter.
- Used as an interval timer or clock-enable divider. The controller loads a period, and the block counts enabled cycles down to expiry.
- Each expiry produces a one-cycle terminal-count pulse and a sticky done flag.
- Runs one-shot or periodic. In periodic mode the block reloads from an internal reload register.

---
 rtl/dec_counter_reload_pkg.sv | 12 +
 rtl/dec_counter_reload.sv | 83 ++++++++
 tb/tb_dec_counter_reload.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dec_counter_reload_pkg.sv
// Shared counter encodings for the reloadable down-counter.
package dec_counter_reload_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/dec_counter_reload.sv
// Programmable down-counter with parallel load, auto-reload,
// terminal-count pulse and sticky done flag.
module dec_counter_reload
  import dec_counter_reload_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             enable,
  input  logic             stop,
  input  logic             mode,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             done,
  output logic             busy,
  output logic             zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    done_d   = done_q;

    if (clear_flag) done_d = 1'b0;

    if (load) begin
      out_d    = data;
      reload_d = data;
      state_d  = (data != '0) ? ST_RUN : ST_IDLE;
    end else if (stop) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_RUN && enable) begin
      // RUN always holds out_q >= 1; a stray zero is left alone
      if (out_q == WIDTH'(1)) begin
        tc_d   = 1'b1;
        done_d = 1'b1;
        if (mode == MODE_PERIODIC) begin
          out_d = reload_q;
        end else begin
          out_d   = '0;
          state_d = ST_IDLE;
        end
      end else if (out_q != '0) begin
        out_d = out_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  assign out  = out_q;
  assign tc   = tc_q;
  assign done = done_q;
  assign busy = (state_q == ST_RUN);
  assign zero = (out_q == '0);

endmodule

// File: tb/tb_dec_counter_reload.sv
// Scoreboard bench for dec_counter_reload (WIDTH=8).
module tb_dec_counter_reload;

  typedef struct packed {
    logic [7:0] out;
    logic       tc;
    logic       done;
    logic       busy;
    logic       zero;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = '0;
  logic       load = 1'b0;
  logic       enable = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic       clear_flag = 1'b0;
  logic [7:0] out;
  logic       tc, done, busy, zero;

  obs_t obs;
  obs_t exp_q[$];
  obs_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  assign obs = {out, tc, done, busy, zero};

  always #5 clk = ~clk;

  dec_counter_reload #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .load      (load),
    .enable    (enable),
    .stop      (stop),
    .mode      (mode),
    .clear_flag(clear_flag),
    .out       (out),
    .tc        (tc),
    .done      (done),
    .busy      (busy),
    .zero      (zero)
  );

  function automatic obs_t ex(logic [7:0] o, logic t, logic d, logic b);
    return {o, t, d, b, (o == 8'd0)};
  endfunction

  task automatic idle_inputs();
    load = 0; stop = 0; enable = 0; clear_flag = 0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (obs !== ex(8'd0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL reset_por got=%h want=%h", obs, ex(8'd0, 0, 0, 0));
    end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      load = (i == 0); data = 8'd10; enable = 1; mode = 0;
      exp_q.push_back(ex(8'(10 - i), 0, 0, 1));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset_pre[%0d] got=%h want=%h", i, obs, e);
      end
    end
    #2 reset = 1;
    #1;
    n_cmp++;
    if (obs !== ex(8'd0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL reset_mid got=%h want=%h", obs, ex(8'd0, 0, 0, 0));
    end
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_oneshot();
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      mode = 0; enable = 1; data = 8'd5; load = (i == 0);
      if (i < 5) exp_q.push_back(ex(8'(5 - i), 0, 0, 1));
      else if (i == 5) exp_q.push_back(ex(8'd0, 1, 1, 0));
      else exp_q.push_back(ex(8'd0, 0, 1, 0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL oneshot[%0d] got=%h want=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_periodic();
    logic [7:0] cnt;
    logic       t, d;
    idle_inputs();
    mode = 1; data = 8'd3; load = 1; clear_flag = 1;
    exp_q.push_back(ex(8'd3, 0, 0, 1));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL periodic_load got=%h want=%h", obs, e);
    end
    cnt = 8'd3; d = 0;
    for (int j = 0; j < 12; j++) begin
      idle_inputs();
      enable = (j % 2 == 0);
      t = 0;
      if (enable) begin
        if (cnt == 8'd1) begin
          cnt = 8'd3; t = 1; d = 1;
        end else cnt = cnt - 8'd1;
      end
      exp_q.push_back(ex(cnt, t, d, 1));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL periodic[%0d] got=%h want=%h", j, obs, e);
      end
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      case (i)
        0: begin stop = 1; exp_q.push_back(ex(8'd3, 0, 1, 0)); end
        1: begin load = 1; data = 8'd0; exp_q.push_back(ex(8'd0, 0, 1, 0)); end
        2: begin
          load = 1; data = 8'd2; mode = 0; enable = 1;
          exp_q.push_back(ex(8'd2, 0, 1, 1));
        end
        3: begin enable = 1; clear_flag = 1; exp_q.push_back(ex(8'd1, 0, 0, 1)); end
        4: begin
          load = 1; data = 8'd4; stop = 1; enable = 1;
          exp_q.push_back(ex(8'd4, 0, 0, 1));
        end
        5: begin stop = 1; enable = 1; exp_q.push_back(ex(8'd4, 0, 0, 0)); end
        default: begin enable = 1; exp_q.push_back(ex(8'd4, 0, 0, 0)); end
      endcase
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL priority[%0d] got=%h want=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_flags();
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      case (i)
        0: begin
          load = 1; data = 8'd1; mode = 1; enable = 1;
          exp_q.push_back(ex(8'd1, 0, 0, 1));
        end
        1, 2, 3: begin enable = 1; exp_q.push_back(ex(8'd1, 1, 1, 1)); end
        4: begin enable = 1; clear_flag = 1; exp_q.push_back(ex(8'd1, 1, 1, 1)); end
        5: begin stop = 1; enable = 1; exp_q.push_back(ex(8'd1, 0, 1, 0)); end
        6: begin clear_flag = 1; exp_q.push_back(ex(8'd1, 0, 0, 0)); end
        default: begin enable = 1; exp_q.push_back(ex(8'd1, 0, 0, 0)); end
      endcase
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL flags[%0d] got=%h want=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_max();
    for (int i = 0; i < 257; i++) begin
      idle_inputs();
      mode = 0; enable = 1; data = 8'hFF; load = (i == 0);
      if (i < 255) exp_q.push_back(ex(8'(255 - i), 0, 0, 1));
      else if (i == 255) exp_q.push_back(ex(8'd0, 1, 1, 0));
      else exp_q.push_back(ex(8'd0, 0, 1, 0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL max[%0d] got=%h want=%h", i, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_priority();
    test_flags();
    test_max();
    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
